// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM interface types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - arbiter state and requester id types
package ram_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Bit 1 selects the class (0 = icache, 1 = dcache), bit 0 the core.
    typedef enum logic [1:0] {
        I0 = 2'd0,
        I1 = 2'd1,
        D0 = 2'd2,
        D1 = 2'd3
    } req_id_t;

    function automatic req_id_t make_id(input logic is_d, input logic core);
        return req_id_t'({is_d, core});
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rtl/ram_arbiter_rr_pick2.sv - two-way round-robin pick within one requester class
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       win
);

    // A lone requester wins outright; a tie is broken by the class pointer.
    always_comb begin
        valid = |req;
        win   = (&req) ? ptr : req[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - four-way RAM port arbiter for two cores' icache/dcache
module ram_arbiter
    import cpu_types_pkg::*;
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int BEAT_W    = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  iREN,
    input  logic [31:0] iaddr0,
    input  logic [31:0] iaddr1,
    output logic [1:0]  iwait,
    output logic [31:0] iload0,
    output logic [31:0] iload1,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr0,
    input  logic [31:0] daddr1,
    input  logic [31:0] dstore0,
    input  logic [31:0] dstore1,
    output logic [1:0]  dwait,
    output logic [31:0] dload0,
    output logic [31:0] dload1,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    arb_state_t        state, state_n;
    req_id_t           owner, owner_n;
    logic [BEAT_W-1:0] beat_cnt, beat_n;
    logic              i_rr, i_rr_n;
    logic              d_rr, d_rr_n;

    logic [1:0] d_req;
    logic       i_valid, i_win;
    logic       d_valid, d_win;
    logic       owner_is_d, owner_core, owner_req;
    logic       ram_access, last_beat;
    word_t      owner_addr, owner_store;

    assign d_req = dREN | dWEN;

    rr_pick2 u_i_pick (
        .req   (iREN),
        .ptr   (i_rr),
        .valid (i_valid),
        .win   (i_win)
    );

    rr_pick2 u_d_pick (
        .req   (d_req),
        .ptr   (d_rr),
        .valid (d_valid),
        .win   (d_win)
    );

    assign owner_is_d = owner[1];
    assign owner_core = owner[0];
    assign ram_access = (ramstate_t'(ramstate) == ACCESS);
    assign last_beat  = (beat_cnt == BEAT_W'(MAX_BEATS - 1));

    // Owner's live request and pass-through address/data selection.
    always_comb begin
        owner_req   = 1'b0;
        owner_addr  = '0;
        owner_store = '0;
        if (owner_is_d) begin
            owner_req   = d_req[owner_core];
            owner_addr  = owner_core ? daddr1 : daddr0;
            owner_store = owner_core ? dstore1 : dstore0;
        end else begin
            owner_req  = iREN[owner_core];
            owner_addr = owner_core ? iaddr1 : iaddr0;
        end
    end

    // Arbiter state, owner, beat count and class round-robin pointers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            owner    <= I0;
            beat_cnt <= '0;
            i_rr     <= 1'b0;
            d_rr     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            beat_cnt <= beat_n;
            i_rr     <= i_rr_n;
            d_rr     <= d_rr_n;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_n = state;
        owner_n = owner;
        beat_n  = beat_cnt;
        i_rr_n  = i_rr;
        d_rr_n  = d_rr;
        case (state)
            IDLE: begin
                // dcaches always beat icaches; RR only breaks ties inside a class
                if (d_valid) begin
                    owner_n = make_id(1'b1, d_win);
                    state_n = GRANT;
                end else if (i_valid) begin
                    owner_n = make_id(1'b0, i_win);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || (ram_access && last_beat)) begin
                    // Release: point the class away from the departing owner.
                    state_n = IDLE;
                    beat_n  = '0;
                    if (owner_is_d) begin
                        d_rr_n = ~owner_core;
                    end else begin
                        i_rr_n = ~owner_core;
                    end
                end else if (ram_access) begin
                    beat_n = beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // RAM strobes, waits and loads; everything idles unless a grant is live.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        iload0   = '0;
        iload1   = '0;
        dload0   = '0;
        dload1   = '0;
        if (state == GRANT) begin
            ramaddr  = owner_addr;
            ramstore = owner_store;
            if (owner_req) begin
                if (owner_is_d && dWEN[owner_core]) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = 1'b1;
                end
            end
            if (owner_is_d) begin
                dwait[owner_core] = ~(owner_req && ram_access);
                if (owner_core) begin
                    dload1 = ramload;
                end else begin
                    dload0 = ramload;
                end
            end else begin
                iwait[owner_core] = ~(owner_req && ram_access);
                if (owner_core) begin
                    iload1 = ramload;
                end else begin
                    iload0 = ramload;
                end
            end
        end
    end

endmodule
